// File: rtl/fpga_cfg_pkg.sv
// ---------------------------------------------------------------------------
// fpga_cfg_pkg
// Shared fixed-point configuration for the math blocks (multiplier, divider).
//   FP_WIDTH        total operand/result bits, two's complement
//   FP_QINT         integer bits including sign
//   FP_QFRAC        fractional bits
//   FP_MUL_LATENCY  fx_mul pipeline depth, accept to valid_out
//   fp_max/fp_min   saturation bounds for a w-bit signed value (w <= 64),
//                   returned sign-extended to 64 bits; callers truncate.
// ---------------------------------------------------------------------------
package fpga_cfg_pkg;

    localparam int FP_WIDTH       = 32;
    localparam int FP_QINT        = 16;
    localparam int FP_QFRAC       = 16;
    localparam int FP_MUL_LATENCY = 3;

    function automatic logic [63:0] fp_max(input int w);
        return (64'd1 << (w - 1)) - 64'd1;
    endfunction

    // Bitwise complement of the max is exactly -2^(w-1), sign-extended.
    function automatic logic [63:0] fp_min(input int w);
        return ~fp_max(w);
    endfunction

endpackage

// File: rtl/fx_mul_pkg.sv
// ---------------------------------------------------------------------------
// fx_mul_pkg
// Pipeline-shape constants for fx_mul.
//   FX_MUL_MIN_LATENCY  operand register + output register
//   fx_prod_stages()    number of product register stages between them
// ---------------------------------------------------------------------------
package fx_mul_pkg;

    localparam int FX_MUL_MIN_LATENCY = 2;

    function automatic int fx_prod_stages(input int latency);
        return latency - FX_MUL_MIN_LATENCY;
    endfunction

endpackage

// File: rtl/fx_mul_if.sv
// ---------------------------------------------------------------------------
// fx_mul_if
// Valid/ready elastic bus of the fixed-point multiplier.
//   upstream   : valid_in, ready_out, a, b
//   downstream : valid_out, ready_in, result, sat_out
//   status     : sat_sticky, clr_sticky
// Modport slave is the multiplier side, master is the user side.
// ---------------------------------------------------------------------------
interface fx_mul_if
    import fpga_cfg_pkg::*;
#(
    parameter int WIDTH = FP_WIDTH
);
    logic             valid_in;
    logic             ready_out;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             valid_out;
    logic             ready_in;
    logic [WIDTH-1:0] result;
    logic             sat_out;
    logic             sat_sticky;
    logic             clr_sticky;

    modport slave (
        input  valid_in, a, b, ready_in, clr_sticky,
        output ready_out, valid_out, result, sat_out, sat_sticky
    );

    modport master (
        output valid_in, a, b, ready_in, clr_sticky,
        input  ready_out, valid_out, result, sat_out, sat_sticky
    );
endinterface

// File: rtl/fx_round_sat.sv
// ---------------------------------------------------------------------------
// fx_round_sat
// Combinational round-half-up and saturate of a full-width signed product
// down to a Q(WIDTH-QFRAC.QFRAC) value.
//   prod_i   : 2*WIDTH signed product
//   result_o : WIDTH-bit rounded/saturated value
//   sat_o    : high when the rounded value was clamped
// ---------------------------------------------------------------------------
module fx_round_sat
    import fpga_cfg_pkg::*;
#(
    parameter int WIDTH = FP_WIDTH,
    parameter int QFRAC = FP_QFRAC
) (
    input  logic signed [2*WIDTH-1:0] prod_i,
    output logic        [WIDTH-1:0]   result_o,
    output logic                      sat_o
);
    localparam int PW = 2 * WIDTH;
    localparam logic signed [PW-1:0] HALF    = PW'(1) << (QFRAC - 1);
    localparam logic [WIDTH-1:0]     SAT_MAX = WIDTH'(fp_max(WIDTH));
    localparam logic [WIDTH-1:0]     SAT_MIN = WIDTH'(fp_min(WIDTH));

    logic signed [PW-1:0] rounded;
    logic signed [PW-1:0] shifted;
    logic        [WIDTH:0] upper;

    // The product of two WIDTH-bit values never reaches the top of the
    // 2*WIDTH range, so adding half an LSB cannot wrap.
    assign rounded = prod_i + HALF;
    assign shifted = rounded >>> QFRAC;
    assign upper   = shifted[PW-1:WIDTH-1];

    // The value fits in WIDTH bits exactly when the bits above the result
    // sign are copies of it.
    always_comb begin
        result_o = shifted[WIDTH-1:0];
        sat_o    = 1'b0;
        if (!((&upper) || !(|upper))) begin
            sat_o    = 1'b1;
            result_o = shifted[PW-1] ? SAT_MIN : SAT_MAX;
        end
    end
endmodule

// File: rtl/fx_mul.sv
// ---------------------------------------------------------------------------
// fx_mul
// Pipelined signed fixed-point multiplier with round-half-up and saturation.
//   clk, rst : clock, synchronous active-high reset (drops in-flight data)
//   bus      : fx_mul_if.slave - valid/ready input of a,b, valid/ready output
//              of result/sat_out, sticky saturation flag with clear
// Stages: 0 operand register, 1..LATENCY-2 product registers,
// LATENCY-1 round/saturate output register. Stalls propagate backwards
// combinationally; empty stages always load so bubbles collapse.
// ---------------------------------------------------------------------------
module fx_mul
    import fpga_cfg_pkg::*;
    import fx_mul_pkg::*;
#(
    parameter int WIDTH   = FP_WIDTH,
    parameter int QINT    = FP_QINT,
    parameter int QFRAC   = FP_QFRAC,
    parameter int LATENCY = FP_MUL_LATENCY
) (
    input  logic     clk,
    input  logic     rst,
    fx_mul_if.slave  bus
);
    localparam int PW          = 2 * WIDTH;
    localparam int PROD_STAGES = fx_prod_stages(LATENCY);

    if ((QINT + QFRAC != WIDTH) || (QFRAC < 1) || (LATENCY < FX_MUL_MIN_LATENCY)) begin : g_bad_cfg
        $error("fx_mul: invalid WIDTH/QINT/QFRAC/LATENCY combination");
    end

    logic [LATENCY-1:0] v_q;   // per-stage valid
    logic [LATENCY-1:0] en;    // per-stage load enable (stage empty or moving on)

    logic [WIDTH-1:0]     a_q;
    logic [WIDTH-1:0]     b_q;
    logic signed [PW-1:0] mult_c;
    logic signed [PW-1:0] round_in;
    logic [WIDTH-1:0]     rs_result;
    logic                 rs_sat;
    logic [WIDTH-1:0]     result_q;
    logic                 sat_q;
    logic                 sticky_q;
    logic                 sticky_d;

    // Advance chain, walked from the output back to the input so that
    // ready_in reaches ready_out in the same cycle.
    always_comb begin
        logic chain;
        chain = bus.ready_in;
        en    = '0;
        for (int k = LATENCY - 1; k >= 0; k--) begin
            chain = !v_q[k] || chain;
            en[k] = chain;
        end
    end

    genvar gi;
    for (gi = 0; gi < LATENCY; gi++) begin : g_valid
        if (gi == 0) begin : g_head
            always_ff @(posedge clk) begin
                if (rst) begin
                    v_q[gi] <= 1'b0;
                end else if (en[gi]) begin
                    v_q[gi] <= bus.valid_in;
                end
            end
        end else begin : g_tail
            always_ff @(posedge clk) begin
                if (rst) begin
                    v_q[gi] <= 1'b0;
                end else if (en[gi]) begin
                    v_q[gi] <= v_q[gi-1];
                end
            end
        end
    end

    // Stage 0: operands.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q <= '0;
            b_q <= '0;
        end else if (en[0] && bus.valid_in) begin
            a_q <= bus.a;
            b_q <= bus.b;
        end
    end

    // Full-width signed product; the sign-extended operands make the low
    // 2*WIDTH bits of the unsized multiply the exact signed product.
    assign mult_c = $signed({{WIDTH{a_q[WIDTH-1]}}, a_q})
                  * $signed({{WIDTH{b_q[WIDTH-1]}}, b_q});

    if (PROD_STAGES == 0) begin : g_direct
        assign round_in = mult_c;
    end else begin : g_prod
        logic signed [PW-1:0] prod_q [PROD_STAGES];

        // Extra product stages give the synthesiser room to retime the
        // multiply across them.
        always_ff @(posedge clk) begin
            if (rst) begin
                for (int j = 0; j < PROD_STAGES; j++) begin
                    prod_q[j] <= '0;
                end
            end else begin
                if (en[1] && v_q[0]) begin
                    prod_q[0] <= mult_c;
                end
                for (int j = 1; j < PROD_STAGES; j++) begin
                    if (en[j+1] && v_q[j]) begin
                        prod_q[j] <= prod_q[j-1];
                    end
                end
            end
        end

        assign round_in = prod_q[PROD_STAGES-1];
    end

    fx_round_sat #(
        .WIDTH (WIDTH),
        .QFRAC (QFRAC)
    ) u_round_sat (
        .prod_i   (round_in),
        .result_o (rs_result),
        .sat_o    (rs_sat)
    );

    // Output stage only loads on real data so a held result stays stable.
    always_ff @(posedge clk) begin
        if (rst) begin
            result_q <= '0;
            sat_q    <= 1'b0;
        end else if (en[LATENCY-1] && v_q[LATENCY-2]) begin
            result_q <= rs_result;
            sat_q    <= rs_sat;
        end
    end

    // Set beats clear when both happen in the same cycle.
    always_comb begin
        sticky_d = sticky_q;
        if (bus.clr_sticky) begin
            sticky_d = 1'b0;
        end
        if (v_q[LATENCY-1] && bus.ready_in && sat_q) begin
            sticky_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sticky_q <= 1'b0;
        end else begin
            sticky_q <= sticky_d;
        end
    end

    assign bus.ready_out  = en[0];
    assign bus.valid_out  = v_q[LATENCY-1];
    assign bus.result     = result_q;
    assign bus.sat_out    = sat_q;
    assign bus.sat_sticky = sticky_q;
endmodule

// File: tb/tb_fx_mul.sv
// ---------------------------------------------------------------------------
// tb_fx_mul
// Directed testbench for fx_mul with WIDTH=32, QFRAC=16, LATENCY=3.
// Inputs are driven 1 time unit after the rising edge, outputs sampled
// 2 time units after it.
// ---------------------------------------------------------------------------
module tb_fx_mul;
    localparam int W   = 32;
    localparam int QI  = 16;
    localparam int QF  = 16;
    localparam int LAT = 3;
    localparam int NV  = 11;

    // Hand-computed vectors: a, b, expected result, expected saturation.
    localparam logic [31:0] VA [NV] = '{
        32'h00018000, 32'hFFFF8000, 32'h00008000, 32'h7FFFFFFF, 32'h80000000,
        32'h80000000, 32'hFFFE8000, 32'h00010000, 32'hFFFF7FFF, 32'h7FFF0000,
        32'h00007FFF};
    localparam logic [31:0] VB [NV] = '{
        32'h00020000, 32'h00000001, 32'h00000001, 32'h7FFFFFFF, 32'h7FFFFFFF,
        32'h80000000, 32'h00020000, 32'hFFFF0000, 32'h00000001, 32'h00010000,
        32'h00000001};
    localparam logic [31:0] VR [NV] = '{
        32'h00030000, 32'h00000000, 32'h00000001, 32'h7FFFFFFF, 32'h80000000,
        32'h7FFFFFFF, 32'hFFFD0000, 32'hFFFF0000, 32'hFFFFFFFF, 32'h7FFF0000,
        32'h00000000};
    localparam logic        VS [NV] = '{
        1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    fx_mul_if #(.WIDTH(W)) bus ();

    fx_mul #(
        .WIDTH   (W),
        .QINT    (QI),
        .QFRAC   (QF),
        .LATENCY (LAT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Single transaction with ready_in high; returns at the cycle valid_out
    // is seen, before the transfer edge. lat = -1 on timeout.
    task automatic run_one(input logic [31:0] a, input logic [31:0] b,
                           output logic [31:0] res, output logic sat, output int lat);
        bus.valid_in = 1'b1;
        bus.a        = a;
        bus.b        = b;
        bus.ready_in = 1'b1;
        tick();
        bus.valid_in = 1'b0;
        lat = -1;
        res = '0;
        sat = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            #1;
            if (bus.valid_out) begin
                res = bus.result;
                sat = bus.sat_out;
                lat = i;
                break;
            end
            tick();
        end
        $display("txn a=%h b=%h -> result=%h sat=%0b latency=%0d", a, b, res, sat, lat);
    endtask

    task automatic test_reset();
        rst            = 1'b1;
        bus.valid_in   = 1'b0;
        bus.a          = '0;
        bus.b          = '0;
        bus.ready_in   = 1'b1;
        bus.clr_sticky = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        #1;
        checks++; if (bus.valid_out !== 1'b0) begin errors++; $display("FAIL reset_valid_out: got %b want 0", bus.valid_out); end
        checks++; if (bus.result !== 32'h0) begin errors++; $display("FAIL reset_result: got %h want 00000000", bus.result); end
        checks++; if (bus.sat_out !== 1'b0) begin errors++; $display("FAIL reset_sat_out: got %b want 0", bus.sat_out); end
        checks++; if (bus.sat_sticky !== 1'b0) begin errors++; $display("FAIL reset_sat_sticky: got %b want 0", bus.sat_sticky); end
        checks++; if (bus.ready_out !== 1'b1) begin errors++; $display("FAIL reset_ready_out: got %b want 1", bus.ready_out); end
    endtask

    task automatic test_basic();
        bus.valid_in = 1'b1;
        bus.a        = 32'h00018000;
        bus.b        = 32'h00020000;
        bus.ready_in = 1'b1;
        #1;
        checks++; if (bus.ready_out !== 1'b1) begin errors++; $display("FAIL basic_ready: got %b want 1", bus.ready_out); end
        tick();
        bus.valid_in = 1'b0;
        #1;
        checks++; if (bus.valid_out !== 1'b0) begin errors++; $display("FAIL basic_early1: valid_out got %b want 0", bus.valid_out); end
        tick();
        #1;
        checks++; if (bus.valid_out !== 1'b0) begin errors++; $display("FAIL basic_early2: valid_out got %b want 0", bus.valid_out); end
        tick();
        #1;
        checks++; if (bus.valid_out !== 1'b1) begin errors++; $display("FAIL basic_latency: valid_out got %b want 1", bus.valid_out); end
        checks++; if (bus.result !== 32'h00030000) begin errors++; $display("FAIL basic_result: got %h want 00030000", bus.result); end
        checks++; if (bus.sat_out !== 1'b0) begin errors++; $display("FAIL basic_sat: got %b want 0", bus.sat_out); end
        $display("txn a=00018000 b=00020000 -> result=%h sat=%0b", bus.result, bus.sat_out);
        tick();
        #1;
        checks++; if (bus.valid_out !== 1'b0) begin errors++; $display("FAIL basic_drain: valid_out got %b want 0", bus.valid_out); end
    endtask

    task automatic test_signs_rounding();
        logic [31:0] res;
        logic        sat;
        int          lat;
        for (int i = 0; i < NV; i++) begin
            run_one(VA[i], VB[i], res, sat, lat);
            checks++; if (lat != LAT) begin errors++; $display("FAIL vec%0d_latency: got %0d want %0d", i, lat, LAT); end
            checks++; if (res !== VR[i]) begin errors++; $display("FAIL vec%0d_result: got %h want %h", i, res, VR[i]); end
            checks++; if (sat !== VS[i]) begin errors++; $display("FAIL vec%0d_sat: got %b want %b", i, sat, VS[i]); end
            tick();
        end
    endtask

    task automatic test_sticky();
        logic [31:0] res;
        logic        sat;
        int          lat;
        bus.clr_sticky = 1'b1;
        tick();
        bus.clr_sticky = 1'b0;
        #1;
        checks++; if (bus.sat_sticky !== 1'b0) begin errors++; $display("FAIL sticky_clear0: got %b want 0", bus.sat_sticky); end

        // Non-saturating transfer leaves the flag clear.
        run_one(32'h00018000, 32'h00020000, res, sat, lat);
        tick();
        #1;
        checks++; if (bus.sat_sticky !== 1'b0) begin errors++; $display("FAIL sticky_nosat: got %b want 0", bus.sat_sticky); end

        run_one(32'h7FFFFFFF, 32'h7FFFFFFF, res, sat, lat);
        checks++; if (res !== 32'h7FFFFFFF || sat !== 1'b1) begin errors++; $display("FAIL sticky_satval: got %h/%b want 7fffffff/1", res, sat); end
        checks++; if (bus.sat_sticky !== 1'b0) begin errors++; $display("FAIL sticky_before: got %b want 0", bus.sat_sticky); end
        tick();
        #1;
        checks++; if (bus.sat_sticky !== 1'b1) begin errors++; $display("FAIL sticky_set: got %b want 1", bus.sat_sticky); end

        bus.clr_sticky = 1'b1;
        tick();
        bus.clr_sticky = 1'b0;
        #1;
        checks++; if (bus.sat_sticky !== 1'b0) begin errors++; $display("FAIL sticky_clear: got %b want 0", bus.sat_sticky); end

        // Clear asserted on the same edge as a saturated transfer: set wins.
        run_one(32'h80000000, 32'h7FFFFFFF, res, sat, lat);
        checks++; if (res !== 32'h80000000 || sat !== 1'b1) begin errors++; $display("FAIL sticky_minval: got %h/%b want 80000000/1", res, sat); end
        bus.clr_sticky = 1'b1;
        tick();
        bus.clr_sticky = 1'b0;
        #1;
        checks++; if (bus.sat_sticky !== 1'b1) begin errors++; $display("FAIL sticky_set_wins: got %b want 1", bus.sat_sticky); end

        bus.clr_sticky = 1'b1;
        tick();
        bus.clr_sticky = 1'b0;
        #1;
        checks++; if (bus.sat_sticky !== 1'b0) begin errors++; $display("FAIL sticky_clear2: got %b want 0", bus.sat_sticky); end
    endtask

    task automatic test_backpressure();
        int          acc = 0;
        int          got = 0;
        int          held;
        int          drop_cyc = 0;
        logic        exp_ready;
        logic        prev_stall = 1'b0;
        logic [31:0] prev_res = '0;
        logic [31:0] exp_res;
        for (int cyc = 1; cyc <= 60 && got < 8; cyc++) begin
            bus.ready_in = !(cyc >= 4 && cyc <= 9);
            bus.valid_in = (acc < 8);
            bus.a        = 32'(acc + 1) << 16;
            bus.b        = 32'h00010000;
            #1;
            held      = acc - got;
            exp_ready = (held < LAT) || bus.ready_in;
            checks++; if (bus.ready_out !== exp_ready) begin errors++; $display("FAIL bp_ready_c%0d: got %b want %b", cyc, bus.ready_out, exp_ready); end
            if (!bus.ready_out && drop_cyc == 0) drop_cyc = cyc;
            if (prev_stall) begin
                checks++;
                if (bus.valid_out !== 1'b1 || bus.result !== prev_res) begin
                    errors++;
                    $display("FAIL bp_stable_c%0d: got %b/%h want 1/%h", cyc, bus.valid_out, bus.result, prev_res);
                end
            end
            if (bus.valid_out && bus.ready_in) begin
                exp_res = 32'(got + 1) << 16;
                $display("txn bp cycle=%0d result=%h", cyc, bus.result);
                checks++; if (bus.result !== exp_res) begin errors++; $display("FAIL bp_order%0d: got %h want %h", got, bus.result, exp_res); end
                got++;
            end
            prev_stall = bus.valid_out && !bus.ready_in;
            prev_res   = bus.result;
            if (bus.valid_in && bus.ready_out) acc++;
            tick();
        end
        bus.valid_in = 1'b0;
        bus.ready_in = 1'b1;
        checks++; if (got != 8) begin errors++; $display("FAIL bp_count: got %0d want 8", got); end
        checks++; if (drop_cyc != 4) begin errors++; $display("FAIL bp_drop_cycle: got %0d want 4", drop_cyc); end
        #1;
        checks++; if (bus.valid_out !== 1'b0) begin errors++; $display("FAIL bp_no_dup: valid_out got %b want 0", bus.valid_out); end
    endtask

    task automatic test_bubbles();
        int   acc = 0;
        int   got = 0;
        int   held;
        logic exp_ready;
        for (int cyc = 1; cyc <= 400 && got < NV; cyc++) begin
            bus.ready_in = 1'($urandom_range(0, 1));
            bus.valid_in = (cyc % 2 == 1) && (acc < NV);
            bus.a        = VA[acc % NV];
            bus.b        = VB[acc % NV];
            #1;
            held      = acc - got;
            exp_ready = (held < LAT) || bus.ready_in;
            checks++; if (bus.ready_out !== exp_ready) begin errors++; $display("FAIL bub_ready_c%0d: got %b want %b", cyc, bus.ready_out, exp_ready); end
            if (bus.valid_out && bus.ready_in) begin
                $display("txn bub cycle=%0d result=%h sat=%0b", cyc, bus.result, bus.sat_out);
                checks++;
                if (bus.result !== VR[got] || bus.sat_out !== VS[got]) begin
                    errors++;
                    $display("FAIL bub_item%0d: got %h/%b want %h/%b", got, bus.result, bus.sat_out, VR[got], VS[got]);
                end
                got++;
            end
            if (bus.valid_in && bus.ready_out) acc++;
            tick();
        end
        bus.valid_in = 1'b0;
        bus.ready_in = 1'b1;
        checks++; if (got != NV) begin errors++; $display("FAIL bub_count: got %0d want %0d", got, NV); end
    endtask

    task automatic test_reset_midflight();
        logic [31:0] res;
        logic        sat;
        int          lat;
        run_one(32'h7FFFFFFF, 32'h7FFFFFFF, res, sat, lat);
        tick();
        #1;
        checks++; if (bus.sat_sticky !== 1'b1) begin errors++; $display("FAIL rmf_sticky_pre: got %b want 1", bus.sat_sticky); end
        bus.ready_in = 1'b1;
        bus.valid_in = 1'b1;
        bus.a        = 32'h00010000;
        bus.b        = 32'h00010000;
        tick();
        bus.a        = 32'h00020000;
        tick();
        bus.valid_in = 1'b0;
        rst          = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        checks++; if (bus.valid_out !== 1'b0) begin errors++; $display("FAIL rmf_valid_out: got %b want 0", bus.valid_out); end
        checks++; if (bus.sat_sticky !== 1'b0) begin errors++; $display("FAIL rmf_sticky: got %b want 0", bus.sat_sticky); end
        checks++; if (bus.ready_out !== 1'b1) begin errors++; $display("FAIL rmf_ready_out: got %b want 1", bus.ready_out); end
        for (int i = 0; i < 6; i++) begin
            tick();
            #1;
            checks++; if (bus.valid_out !== 1'b0) begin errors++; $display("FAIL rmf_stale%0d: valid_out got %b want 0", i, bus.valid_out); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_signs_rounding();
        test_sticky();
        test_backpressure();
        test_bubbles();
        test_reset_midflight();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
